mips_control_unit: RTL
======================

Name: mips_control_unit

Overview:
- Multicycle FSM that drives every control line of the MIPS datapath.
- Receives opcode/funct from the instruction register and status flags from the ALU, multiplier and divider.
- Subset: add, sub, and, jr, mult, div, mfhi, mflo, addi, lw, sw, beq, bne, lui, j, jal.
- Handles three exceptions: invalid opcode, overflow, divide-by-zero.

Parameters:
MEM_WAIT, 1, idle cycles between issuing a memory address and latching its read data (range 1-3).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
overflow  in  1  ALU overflow
zero, lt, gt  in  1 each  ALU flags
mult_done, div_done  in  1 each  multiplier/divider finished (one-cycle pulse)
div_zero  in  1  divisor is zero
iord  out  2  0=PC, 1=ALUOut, 2=exception vector, 3=ALU result
excpControl  out  2  vector select: 0=253 (opcode), 1=254 (overflow), 2=255 (div0)
memWrite, irWrite, regWrite, memRegControl, aControl, bControl, aluOutControl, epcControl, control(PC write), hiControl, loControl, multControl, divControl  out  1 each  register/memory enables, multControl/divControl are start pulses
srcWrite  out  3  destination: 0=rt, 1=rd, 2=r29, 3=r30, 4=r31
srcData  out  4  0=ALUOut, 1=LS, 2=HImult, 3=LOmult, 4=sign-ext imm, 5=imm<<16, 8=const 227, 9=HIdiv, 10=LOdiv
aluSrcA  out  2  0=PC, 1=A, 2=MDR
aluSrcB  out  2  0=B, 1=4, 2=sign-ext imm, 3=sign-ext imm<<2
aluControl  out  3  001 add, 010 sub, 011 and, 111 compare, 000 pass A
pcSource  out  3  0=ALU result, 1=ALUOut, 2=jump concat, 3=MDR, 4=EPC, 5=LS
lsControl, ssControl  out  2 each  1=word, 2=byte

Behaviour:
- Reset (reset=0): state=RESET, all outputs 0, hi_src flag=0.
  - First cycle after release: write r29=227 (regWrite=1, srcWrite=2, srcData=8), then go to FETCH.
  - Reset asserted in any state aborts immediately; no partial writes follow.
- Default: every output not named for a state is 0. Enables are asserted for exactly one cycle.
- FETCH: iord=0, aluSrcA=0, aluSrcB=1, aluControl=add, pcSource=0, control=1 (PC<=PC+4).
- WAIT: MEM_WAIT cycles.
- IRLOAD: irWrite=1.
- DECODE: aControl=bControl=1; ALUOut<=PC+(imm<<2) (aluSrcB=3, add, aluOutControl=1).
  - Dispatch on opcode/funct; any unlisted combination -> EXC_OP.
- R-ALU: A op B -> ALUOut.
  - add/sub with overflow=1 in that cycle -> EXC_OV with no register write.
  - Otherwise next cycle writes rd from ALUOut.
- addi: A + sign-ext imm, same overflow rule, writes rt.
- lui: writes rt with srcData=5 in one cycle.
- lw: ALUOut<=A+imm; iord=1; wait MEM_WAIT; memRegControl=1; write rt with srcData=1, lsControl=1.
- sw: ALUOut<=A+imm; read word; memWrite=1 with ssControl=1.
- beq/bne: compare A,B (aluControl=sub). If zero (beq) or !zero (bne): pcSource=1, control=1. Either way -> FETCH.
- j: pcSource=2, control=1.
- jal: in the same cycle also write r31 from PC (aluSrcA=0, pass A, srcWrite=4).
- jr: pcSource=0 with aluSrcA=1 pass A, control=1.
- mult: multControl pulse, then MWAIT until mult_done; then hiControl=loControl=1 and hi_src<=0.
- div:
  - div_zero sampled in the start cycle: if 1, no divControl pulse, go to EXC_DZ.
  - Else divControl pulse, DWAIT until div_done; hiControl=loControl=1, hi_src<=1.
- mfhi/mflo: srcData = hi_src ? 9/10 : 2/3; write rd.
- No timeout in MWAIT/DWAIT.
- Exceptions (EXC_OP/EXC_OV/EXC_DZ):
  - Cycle 1: EPC<=PC-4 (aluSrcA=0, aluSrcB=1, sub, epcControl=1).
  - Then: iord=2 with excpControl 0/1/2; wait MEM_WAIT; memRegControl=1.
  - Then: pcSource=5 with lsControl=2 (byte), control=1 -> FETCH.
- Latencies with MEM_WAIT=1:
  - add: 6 cycles fetch-to-fetch.
  - lw: 8 cycles.
  - beq: 5 cycles.

Decomposition:
- Shared package `mips_pkg`: opcode/funct localparams, ALU op codes, all mux-select encodings, state enum.
- One sub-module, `mips_ctrl_decode`: combinational opcode/funct -> instruction class plus valid bit.

Test Plan:
- Release reset -> one cycle regWrite=1, srcWrite=2, srcData=8; then iord=0, control=1 in FETCH.
- add with opcode=0, funct=0x20, overflow=0 -> regWrite with srcWrite=1, srcData=0 exactly 5 cycles after FETCH; with overflow=1 -> no regWrite, epcControl pulse, excpControl=1.
- beq with zero=1 -> control=1, pcSource=1 in the branch cycle; zero=0 -> no control pulse, next state FETCH.
- div with div_zero=1 -> divControl never asserted, excpControl=2, final pcSource=5 with lsControl=2; div_zero=0 and div_done after 32 cycles -> hi/lo enables, then mfhi selects srcData=9.
- opcode=0x3F -> EXC_OP; EPC written, iord=2, excpControl=0.
- Reset pulsed low during DWAIT -> all outputs 0 asynchronously, restart at RESET.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, mux selects, states.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_CMP  = 3'b111;

  localparam logic [1:0] IORD_PC     = 2'd0;
  localparam logic [1:0] IORD_ALUOUT = 2'd1;
  localparam logic [1:0] IORD_EXC    = 2'd2;
  localparam logic [1:0] IORD_RES    = 2'd3;

  localparam logic [1:0] EXC_OPC  = 2'd0;
  localparam logic [1:0] EXC_OVF  = 2'd1;
  localparam logic [1:0] EXC_DIV0 = 2'd2;

  localparam logic [2:0] DST_RT  = 3'd0;
  localparam logic [2:0] DST_RD  = 3'd1;
  localparam logic [2:0] DST_R29 = 3'd2;
  localparam logic [2:0] DST_R30 = 3'd3;
  localparam logic [2:0] DST_R31 = 3'd4;

  localparam logic [3:0] SRC_ALUOUT = 4'd0;
  localparam logic [3:0] SRC_LS     = 4'd1;
  localparam logic [3:0] SRC_HIMULT = 4'd2;
  localparam logic [3:0] SRC_LOMULT = 4'd3;
  localparam logic [3:0] SRC_SEXT   = 4'd4;
  localparam logic [3:0] SRC_LUI    = 4'd5;
  localparam logic [3:0] SRC_227    = 4'd8;
  localparam logic [3:0] SRC_HIDIV  = 4'd9;
  localparam logic [3:0] SRC_LODIV  = 4'd10;

  localparam logic [1:0] ASRC_PC  = 2'd0;
  localparam logic [1:0] ASRC_A   = 2'd1;
  localparam logic [1:0] ASRC_MDR = 2'd2;

  localparam logic [1:0] BSRC_B    = 2'd0;
  localparam logic [1:0] BSRC_4    = 2'd1;
  localparam logic [1:0] BSRC_IMM  = 2'd2;
  localparam logic [1:0] BSRC_IMM4 = 2'd3;

  localparam logic [2:0] PC_ALURES = 3'd0;
  localparam logic [2:0] PC_ALUOUT = 3'd1;
  localparam logic [2:0] PC_JUMP   = 3'd2;
  localparam logic [2:0] PC_MDR    = 3'd3;
  localparam logic [2:0] PC_EPC    = 3'd4;
  localparam logic [2:0] PC_LS     = 3'd5;

  localparam logic [1:0] SIZE_WORD = 2'd1;
  localparam logic [1:0] SIZE_BYTE = 2'd2;

  typedef enum logic [3:0] {
    ClsAdd, ClsSub, ClsAnd, ClsJr, ClsMult, ClsDiv, ClsMfhi, ClsMflo,
    ClsAddi, ClsLw, ClsSw, ClsBeq, ClsBne, ClsLui, ClsJ, ClsJal
  } inst_cls_e;

  typedef enum logic [5:0] {
    StReset, StInit, StFetch, StWait, StIrLoad, StDecode,
    StRAlu, StRWrite, StAddi, StAddiWrite, StLui,
    StLwAddr, StLwRead, StLwWait, StLwWrite,
    StSwAddr, StSwRead, StSwWait, StSwWrite,
    StBranch, StJump, StJal, StJr,
    StMult, StMWait, StMultDone,
    StDiv, StDivStart, StDWait, StDivDone,
    StMfhi, StMflo,
    StExc, StExcRead, StExcWait, StExcLoad, StExcJump
  } state_e;

  // One registered copy of every datapath control line.
  typedef struct packed {
    logic [1:0] iord;
    logic [1:0] excp;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_reg;
    logic       a_en;
    logic       b_en;
    logic       alu_out_en;
    logic       epc_en;
    logic       pc_write;
    logic       hi_en;
    logic       lo_en;
    logic       mult_start;
    logic       div_start;
    logic [2:0] src_write;
    logic [3:0] src_data;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [2:0] pc_source;
    logic [1:0] ls_ctrl;
    logic [1:0] ss_ctrl;
  } ctrl_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational opcode/funct decoder: instruction class plus a valid bit.
module mips_ctrl_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output inst_cls_e  cls,
  output logic       valid
);

  // Map the supported subset; anything else is flagged invalid.
  always_comb begin
    cls   = ClsAdd;
    valid = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  cls = ClsAdd;
          FN_SUB:  cls = ClsSub;
          FN_AND:  cls = ClsAnd;
          FN_JR:   cls = ClsJr;
          FN_MULT: cls = ClsMult;
          FN_DIV:  cls = ClsDiv;
          FN_MFHI: cls = ClsMfhi;
          FN_MFLO: cls = ClsMflo;
          default: valid = 1'b0;
        endcase
      end
      OP_ADDI: cls = ClsAddi;
      OP_LW:   cls = ClsLw;
      OP_SW:   cls = ClsSw;
      OP_BEQ:  cls = ClsBeq;
      OP_BNE:  cls = ClsBne;
      OP_LUI:  cls = ClsLui;
      OP_J:    cls = ClsJ;
      OP_JAL:  cls = ClsJal;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_control_unit.sv
// Multicycle MIPS control FSM with registered control outputs.
module mips_control_unit
  import mips_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       overflow,
  input  logic       zero,
  input  logic       lt,
  input  logic       gt,
  input  logic       mult_done,
  input  logic       div_done,
  input  logic       div_zero,
  output logic [1:0] iord,
  output logic [1:0] excpControl,
  output logic       memWrite,
  output logic       irWrite,
  output logic       regWrite,
  output logic       memRegControl,
  output logic       aControl,
  output logic       bControl,
  output logic       aluOutControl,
  output logic       epcControl,
  output logic       control,
  output logic       hiControl,
  output logic       loControl,
  output logic       multControl,
  output logic       divControl,
  output logic [2:0] srcWrite,
  output logic [3:0] srcData,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [2:0] aluControl,
  output logic [2:0] pcSource,
  output logic [1:0] lsControl,
  output logic [1:0] ssControl
);

  localparam logic [1:0] WaitInit = 2'(MEM_WAIT - 1);

  state_e    state_q, state_d;
  inst_cls_e cls_q, cls_d, dec_cls;
  logic      dec_valid;
  logic [1:0] exc_q, exc_d;
  logic [1:0] wait_q, wait_d;
  logic      hi_src_q, hi_src_d;
  ctrl_t     ctrl_q, ctrl_d;
  logic      in_wait, wait_last, br_take;

  // The comparison flags are not needed by this instruction subset.
  logic unused_flags;
  assign unused_flags = lt | gt;

  mips_ctrl_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .cls    (dec_cls),
    .valid  (dec_valid)
  );

  assign in_wait   = (state_q == StWait) || (state_q == StLwWait) ||
                     (state_q == StSwWait) || (state_q == StExcWait);
  assign wait_last = (wait_q == 2'd0);

  // Next-state selection and bookkeeping registers.
  always_comb begin
    state_d  = state_q;
    cls_d    = cls_q;
    exc_d    = exc_q;
    hi_src_d = hi_src_q;
    wait_d   = (in_wait && !wait_last) ? wait_q - 2'd1 : WaitInit;
    case (state_q)
      StReset:  state_d = StInit;
      StInit:   state_d = StFetch;
      StFetch:  state_d = StWait;
      StWait:   if (wait_last) state_d = StIrLoad;
      StIrLoad: state_d = StDecode;
      StDecode: begin
        cls_d = dec_cls;
        if (!dec_valid) begin
          exc_d   = EXC_OPC;
          state_d = StExc;
        end else begin
          case (dec_cls)
            ClsAdd, ClsSub, ClsAnd: state_d = StRAlu;
            ClsJr:   state_d = StJr;
            ClsMult: state_d = StMult;
            ClsDiv:  state_d = StDiv;
            ClsMfhi: state_d = StMfhi;
            ClsMflo: state_d = StMflo;
            ClsAddi: state_d = StAddi;
            ClsLw:   state_d = StLwAddr;
            ClsSw:   state_d = StSwAddr;
            ClsBeq, ClsBne: state_d = StBranch;
            ClsLui:  state_d = StLui;
            ClsJ:    state_d = StJump;
            default: state_d = StJal;
          endcase
        end
      end
      StRAlu: begin
        if (overflow && (cls_q != ClsAnd)) begin
          exc_d   = EXC_OVF;
          state_d = StExc;
        end else begin
          state_d = StRWrite;
        end
      end
      StAddi: begin
        if (overflow) begin
          exc_d   = EXC_OVF;
          state_d = StExc;
        end else begin
          state_d = StAddiWrite;
        end
      end
      StLwAddr:   state_d = StLwRead;
      StLwRead:   state_d = StLwWait;
      StLwWait:   if (wait_last) state_d = StLwWrite;
      StSwAddr:   state_d = StSwRead;
      StSwRead:   state_d = StSwWait;
      StSwWait:   if (wait_last) state_d = StSwWrite;
      StMult:     state_d = StMWait;
      StMWait:    if (mult_done) state_d = StMultDone;
      StMultDone: begin
        hi_src_d = 1'b0;
        state_d  = StFetch;
      end
      StDiv: begin
        if (div_zero) begin
          exc_d   = EXC_DIV0;
          state_d = StExc;
        end else begin
          state_d = StDivStart;
        end
      end
      StDivStart: state_d = StDWait;
      StDWait:    if (div_done) state_d = StDivDone;
      StDivDone: begin
        hi_src_d = 1'b1;
        state_d  = StFetch;
      end
      StExc:      state_d = StExcRead;
      StExcRead:  state_d = StExcWait;
      StExcWait:  if (wait_last) state_d = StExcLoad;
      StExcLoad:  state_d = StExcJump;
      default:    state_d = StFetch;
    endcase
  end

  // Control lines for the state being entered, so they are registered on entry.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      StInit: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.src_write = DST_R29;
        ctrl_d.src_data  = SRC_227;
      end
      StFetch: begin
        ctrl_d.iord      = IORD_PC;
        ctrl_d.alu_src_a = ASRC_PC;
        ctrl_d.alu_src_b = BSRC_4;
        ctrl_d.alu_op    = ALU_ADD;
        ctrl_d.pc_source = PC_ALURES;
        ctrl_d.pc_write  = 1'b1;
      end
      StIrLoad: ctrl_d.ir_write = 1'b1;
      StDecode: begin
        ctrl_d.a_en       = 1'b1;
        ctrl_d.b_en       = 1'b1;
        ctrl_d.alu_src_a  = ASRC_PC;
        ctrl_d.alu_src_b  = BSRC_IMM4;
        ctrl_d.alu_op     = ALU_ADD;
        ctrl_d.alu_out_en = 1'b1;
      end
      StRAlu: begin
        ctrl_d.alu_src_a  = ASRC_A;
        ctrl_d.alu_src_b  = BSRC_B;
        ctrl_d.alu_op     = (cls_d == ClsSub) ? ALU_SUB :
                            (cls_d == ClsAnd) ? ALU_AND : ALU_ADD;
        ctrl_d.alu_out_en = 1'b1;
      end
      StRWrite: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.src_write = DST_RD;
        ctrl_d.src_data  = SRC_ALUOUT;
      end
      StAddi, StLwAddr, StSwAddr: begin
        ctrl_d.alu_src_a  = ASRC_A;
        ctrl_d.alu_src_b  = BSRC_IMM;
        ctrl_d.alu_op     = ALU_ADD;
        ctrl_d.alu_out_en = 1'b1;
      end
      StAddiWrite: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.src_write = DST_RT;
        ctrl_d.src_data  = SRC_ALUOUT;
      end
      StLui: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.src_write = DST_RT;
        ctrl_d.src_data  = SRC_LUI;
      end
      StLwRead, StLwWait, StSwRead, StSwWait: ctrl_d.iord = IORD_ALUOUT;
      StLwWrite: begin
        ctrl_d.mem_reg   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.src_write = DST_RT;
        ctrl_d.src_data  = SRC_LS;
        ctrl_d.ls_ctrl   = SIZE_WORD;
      end
      StSwWrite: begin
        ctrl_d.iord      = IORD_ALUOUT;
        ctrl_d.mem_write = 1'b1;
        ctrl_d.ss_ctrl   = SIZE_WORD;
      end
      StBranch: begin
        ctrl_d.alu_src_a = ASRC_A;
        ctrl_d.alu_src_b = BSRC_B;
        ctrl_d.alu_op    = ALU_SUB;
      end
      StJump: begin
        ctrl_d.pc_source = PC_JUMP;
        ctrl_d.pc_write  = 1'b1;
      end
      StJal: begin
        ctrl_d.pc_source = PC_JUMP;
        ctrl_d.pc_write  = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.src_write = DST_R31;
        ctrl_d.alu_src_a = ASRC_PC;
        ctrl_d.alu_op    = ALU_PASS;
      end
      StJr: begin
        ctrl_d.alu_src_a = ASRC_A;
        ctrl_d.alu_op    = ALU_PASS;
        ctrl_d.pc_source = PC_ALURES;
        ctrl_d.pc_write  = 1'b1;
      end
      StMult:     ctrl_d.mult_start = 1'b1;
      StDivStart: ctrl_d.div_start  = 1'b1;
      StMultDone, StDivDone: begin
        ctrl_d.hi_en = 1'b1;
        ctrl_d.lo_en = 1'b1;
      end
      StMfhi, StMflo: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.src_write = DST_RD;
        if (state_d == StMfhi) ctrl_d.src_data = hi_src_q ? SRC_HIDIV : SRC_HIMULT;
        else                   ctrl_d.src_data = hi_src_q ? SRC_LODIV : SRC_LOMULT;
      end
      StExc: begin
        ctrl_d.alu_src_a = ASRC_PC;
        ctrl_d.alu_src_b = BSRC_4;
        ctrl_d.alu_op    = ALU_SUB;
        ctrl_d.epc_en    = 1'b1;
      end
      StExcRead, StExcWait: begin
        ctrl_d.iord = IORD_EXC;
        ctrl_d.excp = exc_d;
      end
      StExcLoad: begin
        ctrl_d.iord    = IORD_EXC;
        ctrl_d.excp    = exc_d;
        ctrl_d.mem_reg = 1'b1;
      end
      StExcJump: begin
        ctrl_d.pc_source = PC_LS;
        ctrl_d.ls_ctrl   = SIZE_BYTE;
        ctrl_d.pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

  // State and output registers; reset clears every control line immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StReset;
      cls_q    <= ClsAdd;
      exc_q    <= EXC_OPC;
      wait_q   <= WaitInit;
      hi_src_q <= 1'b0;
      ctrl_q   <= '0;
    end else begin
      state_q  <= state_d;
      cls_q    <= cls_d;
      exc_q    <= exc_d;
      wait_q   <= wait_d;
      hi_src_q <= hi_src_d;
      ctrl_q   <= ctrl_d;
    end
  end

  // Branch resolution needs the live ALU zero flag, so the PC write is gated in-cycle.
  assign br_take = (state_q == StBranch) && ((cls_q == ClsBeq) ? zero : !zero);

  assign iord          = ctrl_q.iord;
  assign excpControl   = ctrl_q.excp;
  assign memWrite      = ctrl_q.mem_write;
  assign irWrite       = ctrl_q.ir_write;
  assign regWrite      = ctrl_q.reg_write;
  assign memRegControl = ctrl_q.mem_reg;
  assign aControl      = ctrl_q.a_en;
  assign bControl      = ctrl_q.b_en;
  assign aluOutControl = ctrl_q.alu_out_en;
  assign epcControl    = ctrl_q.epc_en;
  assign control       = ctrl_q.pc_write | br_take;
  assign hiControl     = ctrl_q.hi_en;
  assign loControl     = ctrl_q.lo_en;
  assign multControl   = ctrl_q.mult_start;
  assign divControl    = ctrl_q.div_start;
  assign srcWrite      = ctrl_q.src_write;
  assign srcData       = ctrl_q.src_data;
  assign aluSrcA       = ctrl_q.alu_src_a;
  assign aluSrcB       = ctrl_q.alu_src_b;
  assign aluControl    = ctrl_q.alu_op;
  assign pcSource      = br_take ? PC_ALUOUT : ctrl_q.pc_source;
  assign lsControl     = ctrl_q.ls_ctrl;
  assign ssControl     = ctrl_q.ss_ctrl;

endmodule
